// File: rtl/servio_pkg.sv
// -----------------------------------------------------------------------------
// servio_pkg
// Shared definitions for the SERV boot/run sequencer:
//   - state encoding constants IDLE / LOAD / RELEASE / RUN and the state enum
//   - CRC8_POLY (x^8 + x^2 + x + 1) and a byte-wide CRC-8 update helper, which
//     the top only builds in when SERVIO_BOOT_CRC_EN is defined
// -----------------------------------------------------------------------------
package servio_pkg;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] LOAD    = 2'd1;
   localparam logic [1:0] RELEASE = 2'd2;
   localparam logic [1:0] RUN     = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = IDLE,
      ST_LOAD    = LOAD,
      ST_RELEASE = RELEASE,
      ST_RUN     = RUN
   } state_e;

   localparam logic [7:0] CRC8_POLY = 8'h07;

   // CRC-8, MSB first, no reflection, no output xor: fold the whole byte in,
   // then shift out eight bits.
   function automatic logic [7:0] crc8_update(input logic [7:0] crc_in,
                                              input logic [7:0] data_in);
      logic [7:0] c;
      c = crc_in ^ data_in;
      for (int i = 0; i < 8; i++) begin
         if (c[7]) begin
            c = {c[6:0], 1'b0} ^ CRC8_POLY;
         end else begin
            c = {c[6:0], 1'b0};
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/servio_boot_stagger.sv
// -----------------------------------------------------------------------------
// servio_boot_stagger
// Hart release sequencer. On start_i it latches mask_i and then releases the
// masked harts lowest index first: the first one on the cycle after start_i
// takes effect, each further one STAGGER cycles after the previous one.
// Harts outside the mask stay in reset.
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   clear_i      return every hart to reset and abandon the sequence
//   start_i      one-cycle pulse: begin a sequence with mask_i
//   mask_i       harts to release
//   hart_rst_o   per-hart reset, 1 = held (registered)
//   done_o       1 once every masked hart has been released (registered)
// -----------------------------------------------------------------------------
module servio_boot_stagger #(
   parameter int NUM_HARTS = 4,
   parameter int STAGGER   = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear_i,
   input  logic                 start_i,
   input  logic [NUM_HARTS-1:0] mask_i,
   output logic [NUM_HARTS-1:0] hart_rst_o,
   output logic                 done_o
);

   localparam logic [7:0] GAP_M1 = 8'(STAGGER - 1);
   localparam logic [NUM_HARTS-1:0] ALL_HELD = {NUM_HARTS{1'b1}};
   localparam logic [NUM_HARTS-1:0] NONE     = {NUM_HARTS{1'b0}};

   logic [NUM_HARTS-1:0] pending_q, pending_d;
   logic [NUM_HARTS-1:0] hart_rst_q, hart_rst_d;
   logic [7:0]           timer_q, timer_d;
   logic                 done_q, done_d;
   logic                 picked;

   // Next-state: a zero timer releases the lowest still-pending hart and
   // reloads the gap; otherwise the timer counts down.
   always_comb begin
      pending_d  = pending_q;
      hart_rst_d = hart_rst_q;
      timer_d    = timer_q;
      done_d     = done_q;
      picked     = 1'b0;
      if (clear_i) begin
         pending_d  = NONE;
         hart_rst_d = ALL_HELD;
         timer_d    = 8'd0;
         done_d     = 1'b0;
      end else if (start_i) begin
         pending_d  = mask_i;
         hart_rst_d = ALL_HELD;
         timer_d    = 8'd0;
         done_d     = (mask_i == NONE);
      end else if (pending_q != NONE) begin
         if (timer_q == 8'd0) begin
            for (int i = 0; i < NUM_HARTS; i++) begin
               if (!picked && pending_q[i]) begin
                  picked        = 1'b1;
                  pending_d[i]  = 1'b0;
                  hart_rst_d[i] = 1'b0;
               end else begin
                  picked = picked;
               end
            end
            timer_d = GAP_M1;
            done_d  = (pending_d == NONE);
         end else begin
            timer_d = timer_q - 8'd1;
         end
      end else begin
         timer_d = timer_q;
      end
   end

   // State registers; reset holds every hart.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_q  <= NONE;
         hart_rst_q <= ALL_HELD;
         timer_q    <= 8'd0;
         done_q     <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         hart_rst_q <= hart_rst_d;
         timer_q    <= timer_d;
         done_q     <= done_d;
      end
   end

   assign hart_rst_o = hart_rst_q;
   assign done_o     = done_q;

endmodule

// File: rtl/servio_boot_ctrl.sv
// -----------------------------------------------------------------------------
// servio_boot_ctrl
// Boot/run sequencer for the shared instruction ROM and the SERV harts.
// IDLE -> LOAD (stream cmd_len bytes into the ROM write port) -> RELEASE
// (release masked harts one at a time) -> RUN. cmd_stop returns to IDLE from
// any state and puts every hart and the fetch mux back into reset.
//
// Build option: SERVIO_BOOT_CRC_EN adds a CRC-8 over the loaded image on crc;
// without it crc is tied to zero.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   cmd_load, cmd_len      start a load of cmd_len bytes (IDLE only)
//   cmd_stop               abort/stop, back to IDLE (wins over cmd_load)
//   run_mask               harts to release, sampled when the load completes
//   asi_data/valid/ready   image byte stream, accepted on valid & ready
//   avm_rom_address/write/writedata  ROM write port, one cycle after accept
//   hart_rst               per-hart reset, 1 = held
//   mux_rst                fetch mux reset, 1 in IDLE and LOAD
//   busy                   1 in LOAD or RELEASE
//   error                  sticky bad-length flag, cleared by a good cmd_load
//   crc                    image CRC-8
// -----------------------------------------------------------------------------
module servio_boot_ctrl #(
   parameter int DATA_DEPTH = 1024,
   parameter int NUM_HARTS  = 4,
   parameter int STAGGER    = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            cmd_load,
   input  logic [$clog2(DATA_DEPTH):0]     cmd_len,
   input  logic                            cmd_stop,
   input  logic [NUM_HARTS-1:0]            run_mask,
   input  logic [7:0]                      asi_data,
   input  logic                            asi_valid,
   output logic                            asi_ready,
   output logic [$clog2(DATA_DEPTH)-1:0]   avm_rom_address,
   output logic                            avm_rom_write,
   output logic [7:0]                      avm_rom_writedata,
   output logic [NUM_HARTS-1:0]            hart_rst,
   output logic                            mux_rst,
   output logic                            busy,
   output logic                            error,
   output logic [7:0]                      crc
);

   import servio_pkg::*;

   localparam int AW = $clog2(DATA_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] LEN_ZERO = LW'(0);
   localparam logic [LW-1:0] LEN_ONE  = LW'(1);
   localparam logic [LW-1:0] LEN_MAX  = LW'(DATA_DEPTH);
   localparam logic [NUM_HARTS-1:0] NO_HARTS = {NUM_HARTS{1'b0}};

   state_e           state_q, state_d;
   logic [LW-1:0]    count_q, count_d;
   logic [LW-1:0]    len_q, len_d;
   logic             ready_q, ready_d;
   logic             wr_q, wr_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [7:0]       data_q, data_d;
   logic             mux_rst_q, mux_rst_d;
   logic             busy_q, busy_d;
   logic             error_q, error_d;

   logic                 accept;
   logic                 last_byte;
   logic                 len_ok;
   logic                 load_go;
   logic                 stag_start;
   logic                 stag_done;
   logic [NUM_HARTS-1:0] stag_hart_rst;

   assign accept    = asi_valid & ready_q;
   assign last_byte = (count_q == (len_q - LEN_ONE));
   assign len_ok    = (cmd_len != LEN_ZERO) && (cmd_len <= LEN_MAX);
   assign load_go   = ~cmd_stop & cmd_load & len_ok & (state_q == ST_IDLE);

   // Sequencer next-state and registered-output values.
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      len_d      = len_q;
      ready_d    = ready_q;
      wr_d       = 1'b0;
      addr_d     = addr_q;
      data_d     = data_q;
      error_d    = error_q;
      stag_start = 1'b0;

      // A completed handshake always reaches the ROM, even if a stop
      // arrives in the same cycle; the source saw it as accepted.
      if (accept) begin
         wr_d   = 1'b1;
         addr_d = count_q[AW-1:0];
         data_d = asi_data;
      end else begin
         wr_d = 1'b0;
      end

      if (cmd_stop) begin
         state_d = ST_IDLE;
         ready_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (load_go) begin
                  state_d = ST_LOAD;
                  count_d = LEN_ZERO;
                  len_d   = cmd_len;
                  ready_d = 1'b1;
                  error_d = 1'b0;
               end else if (cmd_load) begin
                  error_d = 1'b1;
               end else begin
                  error_d = error_q;
               end
            end
            ST_LOAD: begin
               if (accept) begin
                  count_d = count_q + LEN_ONE;
                  if (last_byte) begin
                     ready_d    = 1'b0;
                     stag_start = 1'b1;
                     // Nothing to release: skip straight to RUN.
                     state_d    = (run_mask == NO_HARTS) ? ST_RUN : ST_RELEASE;
                  end else begin
                     ready_d = 1'b1;
                  end
               end else begin
                  count_d = count_q;
               end
            end
            ST_RELEASE: begin
               if (stag_done) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_RELEASE;
               end
            end
            ST_RUN: begin
               state_d = ST_RUN;
            end
            default: begin
               state_d = ST_IDLE;
               ready_d = 1'b0;
            end
         endcase
      end

      mux_rst_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
      busy_d    = (state_d == ST_LOAD) || (state_d == ST_RELEASE);
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         count_q   <= LEN_ZERO;
         len_q     <= LEN_ZERO;
         ready_q   <= 1'b0;
         wr_q      <= 1'b0;
         addr_q    <= {AW{1'b0}};
         data_q    <= 8'h00;
         mux_rst_q <= 1'b1;
         busy_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         len_q     <= len_d;
         ready_q   <= ready_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         mux_rst_q <= mux_rst_d;
         busy_q    <= busy_d;
         error_q   <= error_d;
      end
   end

   servio_boot_stagger #(
      .NUM_HARTS (NUM_HARTS),
      .STAGGER   (STAGGER)
   ) u_stagger (
      .clk        (clk),
      .reset      (reset),
      .clear_i    (cmd_stop),
      .start_i    (stag_start),
      .mask_i     (run_mask),
      .hart_rst_o (stag_hart_rst),
      .done_o     (stag_done)
   );

`ifdef SERVIO_BOOT_CRC_EN
   logic [7:0] crc_q, crc_d;

   // Image CRC: restart on an accepted load, fold in every accepted byte.
   always_comb begin
      crc_d = crc_q;
      if (load_go) begin
         crc_d = 8'h00;
      end else if (accept) begin
         crc_d = crc8_update(crc_q, asi_data);
      end else begin
         crc_d = crc_q;
      end
   end

   // CRC register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         crc_q <= 8'h00;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;
`else
   assign crc = 8'h00;
`endif

   assign asi_ready         = ready_q;
   assign avm_rom_address   = addr_q;
   assign avm_rom_write     = wr_q;
   assign avm_rom_writedata = data_q;
   assign hart_rst          = stag_hart_rst;
   assign mux_rst           = mux_rst_q;
   assign busy              = busy_q;
   assign error             = error_q;

endmodule

// File: tb/tb_servio_boot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_servio_boot_ctrl
// Randomized bench for servio_boot_ctrl with a behavioural reference model.
// The driver updates the model at every clock edge from the inputs it drove;
// ROM writes are pushed to a scoreboard queue with their due cycle, hart
// releases are kept as a per-hart release-cycle schedule. A negedge monitor
// pops and compares writes and checks the status outputs against the model.
// -----------------------------------------------------------------------------
module tb_servio_boot_ctrl;

   localparam int DEPTH = 1024;
   localparam int NH    = 4;
   localparam int STG   = 16;
   localparam int AW    = 10;

   logic            clk = 1'b0;
   logic            reset;
   logic            cmd_load;
   logic [AW:0]     cmd_len;
   logic            cmd_stop;
   logic [NH-1:0]   run_mask;
   logic [7:0]      asi_data;
   logic            asi_valid;
   logic            asi_ready;
   logic [AW-1:0]   avm_rom_address;
   logic            avm_rom_write;
   logic [7:0]      avm_rom_writedata;
   logic [NH-1:0]   hart_rst;
   logic            mux_rst;
   logic            busy;
   logic            error;
   logic [7:0]      crc;

   always #5 clk = ~clk;

   servio_boot_ctrl #(
      .DATA_DEPTH (DEPTH),
      .NUM_HARTS  (NH),
      .STAGGER    (STG)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .cmd_load          (cmd_load),
      .cmd_len           (cmd_len),
      .cmd_stop          (cmd_stop),
      .run_mask          (run_mask),
      .asi_data          (asi_data),
      .asi_valid         (asi_valid),
      .asi_ready         (asi_ready),
      .avm_rom_address   (avm_rom_address),
      .avm_rom_write     (avm_rom_write),
      .avm_rom_writedata (avm_rom_writedata),
      .hart_rst          (hart_rst),
      .mux_rst           (mux_rst),
      .busy              (busy),
      .error             (error),
      .crc               (crc)
   );

   typedef struct {
      int addr;
      int data;
      int cyc;
   } wr_t;

   int   cyc    = 0;
   int   n_cmp  = 0;
   int   n_bad  = 0;
   wr_t  wq[$];
   wr_t  mon_w;
   int   rel_cyc[NH];

   // reference model: 0 idle, 1 loading, 2 releasing/running
   int         m_state;
   int         m_count;
   int         m_len;
   bit         m_ready;
   bit         m_mux;
   bit         m_err;
   logic [7:0] m_crc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Polynomial long division, one message bit at a time.
   function automatic logic [7:0] ref_crc(input logic [7:0] c, input logic [7:0] d);
      logic [7:0] r;
      logic       fb;
      r = c;
      for (int b = 7; b >= 0; b--) begin
         fb = r[7] ^ d[b];
         r  = {r[6:0], 1'b0};
         if (fb) r = r ^ 8'h07;
      end
      return r;
   endfunction

   function automatic logic [NH-1:0] exp_hart();
      logic [NH-1:0] v;
      for (int i = 0; i < NH; i++) v[i] = !(rel_cyc[i] >= 0 && cyc >= rel_cyc[i]);
      return v;
   endfunction

   task automatic model_reset();
      m_state = 0;
      m_count = 0;
      m_len   = 0;
      m_ready = 1'b0;
      m_mux   = 1'b1;
      m_err   = 1'b0;
      m_crc   = 8'h00;
      for (int i = 0; i < NH; i++) rel_cyc[i] = -1;
      wq.delete();
   endtask

   // Apply the rules for the edge that just happened, using the inputs held
   // across it.
   task automatic model_edge();
      int t;
      if (reset) begin
         model_reset();
      end else if (cmd_stop) begin
         m_state = 0;
         m_ready = 1'b0;
         m_mux   = 1'b1;
         for (int i = 0; i < NH; i++) rel_cyc[i] = -1;
      end else if (m_state == 0) begin
         if (cmd_load) begin
            if (cmd_len >= 1 && cmd_len <= DEPTH) begin
               m_state = 1;
               m_count = 0;
               m_len   = int'(cmd_len);
               m_err   = 1'b0;
               m_ready = 1'b1;
               m_crc   = 8'h00;
            end else begin
               m_err = 1'b1;
            end
         end
      end else if (m_state == 1) begin
         if (asi_valid && m_ready) begin
            wq.push_back('{addr: m_count, data: int'(asi_data), cyc: cyc});
            m_crc   = ref_crc(m_crc, asi_data);
            m_count = m_count + 1;
            if (m_count == m_len) begin
               m_ready = 1'b0;
               m_mux   = 1'b0;
               m_state = 2;
               t = cyc + 1;
               for (int i = 0; i < NH; i++) begin
                  if (run_mask[i]) begin
                     rel_cyc[i] = t;
                     t = t + STG;
                  end
               end
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      model_edge();
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_load(input int len, input logic [NH-1:0] mask);
      cmd_load = 1'b1;
      cmd_len  = len[AW:0];
      run_mask = mask;
      tick();
      cmd_load = 1'b0;
   endtask

   task automatic do_stop();
      cmd_stop = 1'b1;
      tick();
      cmd_stop = 1'b0;
   endtask

   // mode 0: back to back, 1: valid every other cycle, 2: random gaps
   task automatic send_bytes(input logic [7:0] bytes[$], input int mode);
      int gap;
      for (int i = 0; i < bytes.size(); i++) begin
         asi_valid = 1'b1;
         asi_data  = bytes[i];
         tick();
         asi_valid = 1'b0;
         gap = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
         for (int g = 0; g < gap; g++) begin
            asi_data = 8'($urandom);
            tick();
         end
      end
      asi_valid = 1'b0;
   endtask

   // Monitor: pop the write scoreboard and compare status against the model.
   always @(negedge clk) begin
      while (wq.size() > 0 && wq[0].cyc < cyc) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wr_missing: got no write expected addr %0h data %0h at cycle %0d",
                  wq[0].addr, wq[0].data, wq[0].cyc);
         void'(wq.pop_front());
      end
      if (avm_rom_write === 1'b1) begin
         if (wq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wr_unexpected: got write addr %0h data %0h expected none (cycle %0d)",
                     avm_rom_address, avm_rom_writedata, cyc);
         end else begin
            mon_w = wq.pop_front();
            check("wr_addr", 32'(avm_rom_address), mon_w.addr);
            check("wr_data", 32'(avm_rom_writedata), mon_w.data);
            check("wr_cycle", cyc, mon_w.cyc);
         end
      end else begin
         check("wr_strobe", 32'(avm_rom_write), 32'd0);
      end
      check("hart_rst", 32'(hart_rst), 32'(exp_hart()));
      check("mux_rst", 32'(mux_rst), 32'(m_mux));
      check("asi_ready", 32'(asi_ready), 32'(m_ready));
      check("error", 32'(error), 32'(m_err));
`ifdef SERVIO_BOOT_CRC_EN
      check("crc", 32'(crc), 32'(m_crc));
`else
      check("crc", 32'(crc), 32'h0);
`endif
      if (m_state < 2) check("busy", 32'(busy), (m_state == 1) ? 32'd1 : 32'd0);
   end

   initial begin
      logic [7:0] b[$];
      int len;
      int cut;
      logic [NH-1:0] mask;

      reset     = 1'b1;
      cmd_load  = 1'b0;
      cmd_stop  = 1'b0;
      cmd_len   = '0;
      run_mask  = '0;
      asi_data  = 8'h00;
      asi_valid = 1'b0;
      model_reset();
      wait_cycles(3);
      reset = 1'b0;
      check("rst_addr", 32'(avm_rom_address), 32'd0);
      check("rst_wdata", 32'(avm_rom_writedata), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      wait_cycles(2);

      // single hart, four fixed bytes
      do_load(4, 4'b0001);
      b = '{8'h13, 8'h00, 8'h00, 8'h00};
      send_bytes(b, 0);
      wait_cycles(6);
      check("t1_hart", 32'(hart_rst), 32'h0000000E);
      do_stop();
      check("t1_stop_hart", 32'(hart_rst), 32'h0000000F);

      // all harts, valid every other cycle
      do_load(8, 4'b1111);
      b.delete();
      for (int i = 0; i < 8; i++) b.push_back(8'($urandom));
      send_bytes(b, 1);
      wait_cycles(60);
      check("t2_hart", 32'(hart_rst), 32'h0);
      do_stop();

      // bad lengths, then a good load clears error; load in RUN is ignored
      do_load(0, 4'b0001);
      check("t3_err_zero", 32'(error), 32'd1);
      do_load(DEPTH + 1, 4'b0001);
      check("t3_err_big", 32'(error), 32'd1);
      wait_cycles(3);
      do_load(5, 4'($urandom));
      check("t3_err_clear", 32'(error), 32'd0);
      b.delete();
      for (int i = 0; i < 5; i++) b.push_back(8'($urandom));
      send_bytes(b, 2);
      wait_cycles(70);
      do_load(3, 4'b1111);
      asi_valid = 1'b1;
      wait_cycles(4);
      asi_valid = 1'b0;
      do_stop();

      // stop after 3 of 10 bytes; further valid bytes must not be taken
      do_load(10, 4'b0011);
      b.delete();
      for (int i = 0; i < 3; i++) b.push_back(8'($urandom));
      send_bytes(b, 0);
      do_stop();
      check("t4_ready", 32'(asi_ready), 32'd0);
      check("t4_hart", 32'(hart_rst), 32'h0000000F);
      asi_valid = 1'b1;
      wait_cycles(4);
      asi_valid = 1'b0;
      wait_cycles(2);

      // randomized loads, partial loads, stops during release
      for (int it = 0; it < 12; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            cmd_load = 1'b1;
            cmd_stop = 1'b1;
            cmd_len  = '0;
            tick();
            cmd_load = 1'b0;
            cmd_stop = 1'b0;
         end
         len  = int'($urandom_range(1, 24));
         mask = 4'($urandom_range(0, 15));
         do_load(len, mask);
         cut = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : len;
         b.delete();
         for (int i = 0; i < cut; i++) b.push_back(8'($urandom));
         send_bytes(b, 2);
         wait_cycles((cut < len) ? 2 : int'($urandom_range(0, 70)));
         do_stop();
         wait_cycles(2);
      end

      // full-depth image, top address reached
      do_load(DEPTH, 4'b1000);
      b.delete();
      for (int i = 0; i < DEPTH; i++) b.push_back(8'($urandom));
      send_bytes(b, 0);
      wait_cycles(5);
      check("t6_hart", 32'(hart_rst), 32'h00000007);
      do_stop();

      // async reset with two harts released
      do_load(2, 4'b1111);
      b = '{8'hA5, 8'h5A};
      send_bytes(b, 0);
      wait_cycles(20);
      check("t7_two_released", 32'(hart_rst), 32'h0000000C);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check("t7_async_hart", 32'(hart_rst), 32'h0000000F);
      check("t7_async_mux", 32'(mux_rst), 32'd1);
      check("t7_async_ready", 32'(asi_ready), 32'd0);
      wait_cycles(2);
      reset = 1'b0;
      wait_cycles(2);

      // CRC check image "123456789"
      do_load(9, 4'b0010);
      b.delete();
      for (int i = 1; i <= 9; i++) b.push_back(8'(8'h30 + i));
      send_bytes(b, 2);
      wait_cycles(4);
`ifdef SERVIO_BOOT_CRC_EN
      check("t8_crc_check", 32'(crc), 32'h000000F4);
`endif
      do_stop();
      wait_cycles(4);
      check("final_wq_empty", wq.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/servio_boot_ctrl.md
Name: servio_boot_ctrl

Overview:
- Boot/run sequencer for the shared instruction ROM and the four SERV harts.
- Loads a program image from a byte stream into the ROM write port, then releases hart resets one at a time.
- Holds harts in reset whenever the ROM contents are being changed.
- Replaces the fixed stop/sclr register in the top level; its outputs drive the ROM write port and the mux/hart resets.

Parameters:
- DATA_DEPTH, 1024, ROM depth in bytes; address width aw = $clog2(DATA_DEPTH).
- NUM_HARTS, 4, number of harts under control (1..4).
- STAGGER, 16, cycles between successive hart releases (1..255).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_load  in  1  one-cycle pulse: start an image load.
- cmd_len  in  aw+1  image length in bytes; sampled on cmd_load.
- cmd_stop  in  1  one-cycle pulse: abort/stop, return to IDLE.
- run_mask  in  NUM_HARTS  harts to release after load; sampled on load completion.
- asi_data  in  8  image byte.
- asi_valid  in  1  byte valid.
- asi_ready  out  1  byte accepted when valid&ready.
- avm_rom_address  out  aw  ROM write address.
- avm_rom_write  out  1  ROM write strobe.
- avm_rom_writedata  out  8  ROM write data.
- hart_rst  out  NUM_HARTS  per-hart reset, 1 = held.
- mux_rst  out  1  fetch mux reset; 1 while any load is active or in IDLE.
- busy  out  1  state is LOAD or RELEASE.
- error  out  1  sticky: bad length; cleared by the next accepted cmd_load.
- crc  out  8  image CRC (see Optional Feature).

Behaviour:
- Reset values: state IDLE; asi_ready=0, avm_rom_write=0, address=0, writedata=0, hart_rst=all 1, mux_rst=1, busy=0, error=0, crc=0.
- States:
  - IDLE: all harts held, mux_rst=1.
    - cmd_load with 1 <= cmd_len <= DATA_DEPTH -> LOAD; count=0.
    - cmd_len=0 or cmd_len > DATA_DEPTH -> error=1, stay IDLE.
  - LOAD: asi_ready=1. Each accepted byte is registered and drives avm_rom_write=1 with address=count the next cycle (1-cycle latency), then count increments.
    - When the byte at count=len-1 is accepted -> RELEASE, and asi_ready drops the next cycle.
    - At most one byte per cycle; the address never wraps because len <= DATA_DEPTH.
  - RELEASE: sample run_mask on entry; mux_rst drops on entry. Each hart in run_mask deasserts hart_rst in index order, lowest first. The first release happens one cycle after entry; each further release follows STAGGER cycles later. Harts outside the mask remain held.
    - After the last masked hart is released -> RUN.
    - An empty mask goes -> RUN immediately.
  - RUN: harts as released; cmd_load is ignored; only cmd_stop acts.
- cmd_stop in any state -> IDLE next cycle:
  - all hart_rst=1, mux_rst=1, asi_ready=0.
  - A write already registered still completes; no new bytes are accepted.
- cmd_load outside IDLE is ignored. cmd_load and cmd_stop in the same cycle: stop wins.
- Async reset mid-load: immediate return to reset values; the partial image stays in ROM.

Optional Feature:
- SERVIO_BOOT_CRC_EN defined:
  - crc is a CRC-8 (poly 0x07, init 0x00, no reflection, no xorout) over accepted bytes.
  - It updates on each accept and clears on cmd_load acceptance.
  - It is stable from RELEASE onward.
- Undefined: crc tied to 8'h00 and no CRC logic is built.

Decomposition:
- Package servio_pkg: state encoding localparams (IDLE, LOAD, RELEASE, RUN), CRC8_POLY=8'h07.
- One sub-module: servio_boot_stagger, the release sequencer that takes mask/start/STAGGER and produces the hart_rst vector and a done signal.

Test Plan:
- Load 4 bytes {13,00,00,00}, run_mask=4'b0001 -> ROM writes at addresses 0..3 one cycle after each accept; hart_rst[0] falls one cycle after RELEASE entry; hart_rst[3:1] stay 1.
- Load 8 bytes with asi_valid toggled every other cycle, run_mask=4'b1111, STAGGER=16 -> exactly 8 writes; hart releases at RELEASE entry +1, +17, +33, +49 cycles.
- cmd_len=0, then cmd_len=DATA_DEPTH+1 -> error=1, state stays IDLE, no ROM writes; a following valid cmd_load clears error.
- Assert cmd_stop after 3 of 10 bytes -> IDLE; no write beyond address 2 (3 if a byte was registered); asi_ready=0; all hart_rst=1.
- Assert async reset during RELEASE with two harts already released -> all hart_rst=1 and mux_rst=1 immediately, without waiting for a clock edge.
- (CRC_EN) Load the ASCII bytes "123456789" -> crc=8'hF4.
